// File: rtl/ours_axi4_b_ord_demux.sv
// Write-response return path: steers each downstream B beat back to the input
// whose AW was accepted in the same order, using an order FIFO of grant indices.

module ours_axi4_b_ord_demux #(
  parameter int N_INPUT   = 2,
  parameter int B_WIDTH   = 2,
  parameter int ORD_DEPTH = 4,
  parameter int IDX_W     = (N_INPUT > 1) ? $clog2(N_INPUT) : 1,
  localparam int OUT_W    = $clog2(ORD_DEPTH + 2)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ord_push_vld,
  input  logic [IDX_W-1:0]             ord_push_idx,
  output logic                         ord_push_rdy,
  input  logic                         master_bvld,
  input  logic [B_WIDTH-1:0]           master_b,
  output logic                         master_brdy,
  output logic [N_INPUT-1:0]           slave_bvld,
  output logic [N_INPUT*B_WIDTH-1:0]   slave_b,
  input  logic [N_INPUT-1:0]           slave_brdy,
  output logic [OUT_W-1:0]             outstanding,
  output logic                         clk_en
);

  localparam int PTR_W = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
  localparam int CNT_W = $clog2(ORD_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ORD_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ORD_DEPTH);

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_PTR) r = {PTR_W{1'b0}};
    else               r = p + PTR_W'(1);
    return r;
  endfunction

  logic [IDX_W-1:0]   mem [ORD_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic               out_vld;
  logic [IDX_W-1:0]   out_idx;
  logic [B_WIDTH-1:0] out_b;
  logic [IDX_W-1:0]   head;
  logic               push;
  logic               pop;
  logic               out_hs;

  // Single-initiator build never routes anywhere but lane 0.
  generate
    if (N_INPUT == 1) begin : g_single
      assign head = {IDX_W{1'b0}};
    end else begin : g_multi
      assign head = mem[rd_ptr];
    end
  endgenerate

  // Output lane decode; every lane carries the same held payload.
  always_comb begin
    slave_bvld = {N_INPUT{1'b0}};
    slave_b    = {(N_INPUT*B_WIDTH){1'b0}};
    for (int i = 0; i < N_INPUT; i++) begin
      slave_bvld[i] = out_vld & (out_idx == IDX_W'(i));
      slave_b[i*B_WIDTH +: B_WIDTH] = out_b;
    end
  end

  assign out_hs       = |(slave_bvld & slave_brdy);
  assign ord_push_rdy = (count != FULL_CNT);
  assign master_brdy  = (count != {CNT_W{1'b0}}) & (~out_vld | out_hs);
  assign push         = ord_push_vld & ord_push_rdy;
  assign pop          = master_bvld & master_brdy;
  assign outstanding  = OUT_W'(count) + OUT_W'(out_vld);
  assign clk_en       = ~rstn | (count != {CNT_W{1'b0}}) | out_vld | master_bvld | ord_push_vld;

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Order FIFO storage (contents are don't-care while count is zero).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ord_push_idx;
    end
  end

  // FIFO pointers/count and the one-entry B output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr  <= {PTR_W{1'b0}};
      wr_ptr  <= {PTR_W{1'b0}};
      count   <= {CNT_W{1'b0}};
      out_vld <= 1'b0;
      out_idx <= {IDX_W{1'b0}};
      out_b   <= {B_WIDTH{1'b0}};
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
      if (pop) begin
        out_vld <= 1'b1;
        out_idx <= head;
        out_b   <= master_b;
      end else if (out_hs) begin
        out_vld <= 1'b0;
      end
    end
  end

  ours_axi4_b_ord_demux_chk #(
    .N_INPUT (N_INPUT),
    .IDX_W   (IDX_W)
  ) u_chk (
    .clk          (clk),
    .rstn         (rstn),
    .ord_push_vld (ord_push_vld),
    .ord_push_idx (ord_push_idx),
    .ord_push_rdy (ord_push_rdy),
    .master_bvld  (master_bvld),
    .fifo_empty   (count == {CNT_W{1'b0}})
  );

endmodule

// Protocol checks for the order demux: push overflow, bad index, long B stall.
module ours_axi4_b_ord_demux_chk #(
  parameter int N_INPUT = 2,
  parameter int IDX_W   = 1
) (
  input logic             clk,
  input logic             rstn,
  input logic             ord_push_vld,
  input logic [IDX_W-1:0] ord_push_idx,
  input logic             ord_push_rdy,
  input logic             master_bvld,
  input logic             fifo_empty
);

  logic [10:0] stall_cnt;

  // Saturating count of cycles a B beat waits with nothing recorded.
  always_ff @(posedge clk) begin
    if (!rstn || !(master_bvld && fifo_empty)) stall_cnt <= 11'd0;
    else if (stall_cnt != 11'h7ff)             stall_cnt <= stall_cnt + 11'd1;
  end

  a_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    ord_push_vld |-> ord_push_rdy)
    else $error("order push while FIFO full");

  a_push_idx_range: assert property (@(posedge clk) disable iff (!rstn)
    ord_push_vld |-> (32'(ord_push_idx) < N_INPUT))
    else $error("order push index out of range");

  a_b_stall: assert property (@(posedge clk) disable iff (!rstn)
    stall_cnt <= 11'd1024)
    else $warning("B beat stalled over 1024 cycles with no recorded write");

endmodule

// File: tb/tb_ours_axi4_b_ord_demux.sv
// Bench for ours_axi4_b_ord_demux: queue-based reference model plus directed
// scenarios with hand-computed expectations, followed by randomized traffic.

module tb_ours_axi4_b_ord_demux;
  localparam int N  = 4;
  localparam int BW = 2;
  localparam int D  = 3;
  localparam int IW = 2;
  localparam int OW = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              ord_push_vld;
  logic [IW-1:0]     ord_push_idx;
  logic              ord_push_rdy;
  logic              master_bvld;
  logic [BW-1:0]     master_b;
  logic              master_brdy;
  logic [N-1:0]      slave_bvld;
  logic [N*BW-1:0]   slave_b;
  logic [N-1:0]      slave_brdy;
  logic [OW-1:0]     outstanding;
  logic              clk_en;

  always #5 clk = ~clk;

  ours_axi4_b_ord_demux #(.N_INPUT(N), .B_WIDTH(BW), .ORD_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn),
    .ord_push_vld(ord_push_vld), .ord_push_idx(ord_push_idx), .ord_push_rdy(ord_push_rdy),
    .master_bvld(master_bvld), .master_b(master_b), .master_brdy(master_brdy),
    .slave_bvld(slave_bvld), .slave_b(slave_b), .slave_brdy(slave_brdy),
    .outstanding(outstanding), .clk_en(clk_en)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: outstanding routes in order, plus the beat being presented.
  int          q[$];
  logic        m_vld;
  int          m_idx;
  logic [BW-1:0] m_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_brdy();
    return (q.size() != 0) && (!m_vld || slave_brdy[m_idx]);
  endfunction

  task automatic model_reset();
    q.delete();
    m_vld = 1'b0;
    m_idx = 0;
    m_b   = '0;
  endtask

  // Drive one cycle of inputs at negedge, then compare all outputs to the model.
  task automatic cyc(input logic r, input logic pv, input int pi, input logic bv,
                     input int b, input logic [N-1:0] sr);
    logic [N-1:0] exp_bvld;
    logic [BW-1:0] lane;
    @(negedge clk);
    rstn = r; ord_push_vld = pv; ord_push_idx = IW'(pi);
    master_bvld = bv; master_b = BW'(b); slave_brdy = sr;
    #1;
    exp_bvld = m_vld ? (N'(1) << m_idx) : '0;
    chk("slave_bvld", 32'(slave_bvld), 32'(exp_bvld));
    chk("master_brdy", 32'(master_brdy), 32'(model_brdy()));
    chk("ord_push_rdy", 32'(ord_push_rdy), 32'(q.size() != D));
    chk("outstanding", 32'(outstanding), 32'(q.size() + int'(m_vld)));
    chk("clk_en", 32'(clk_en),
        32'(!rstn || q.size() != 0 || m_vld || master_bvld || ord_push_vld));
    for (int i = 0; i < N; i++) begin
      lane = slave_b[i*BW +: BW];
      chk("slave_b", 32'(lane), 32'(m_b));
    end
  endtask

  // Advance the model by the clock edge that follows the current inputs.
  task automatic adv();
    logic pop, ohs, psh;
    if (!rstn) begin
      model_reset();
    end else begin
      pop = master_bvld && model_brdy();
      ohs = m_vld && slave_brdy[m_idx];
      psh = ord_push_vld && (q.size() != D);
      if (pop) begin
        m_idx = q.pop_front();
        m_b   = master_b;
        m_vld = 1'b1;
      end else if (ohs) begin
        m_vld = 1'b0;
      end
      if (psh) q.push_back(int'(ord_push_idx));
    end
  endtask

  task automatic step(input logic r, input logic pv, input int pi, input logic bv,
                      input int b, input logic [N-1:0] sr);
    cyc(r, pv, pi, bv, b, sr);
    adv();
  endtask

  initial begin
    rstn = 1'b0; ord_push_vld = 1'b0; ord_push_idx = '0;
    master_bvld = 1'b0; master_b = '0; slave_brdy = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    cyc(1, 0, 0, 0, 0, 4'b0000);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_push_rdy", 32'(ord_push_rdy), 32'd1);
    chk("rst_bvld", 32'(slave_bvld), 32'd0);
    chk("rst_brdy", 32'(master_brdy), 32'd0);
    adv();

    // Basic routing: push 2, 0; beats 00 then 10
    step(1, 1, 2, 0, 0, 4'b1111);
    step(1, 1, 0, 0, 0, 4'b1111);
    cyc(1, 0, 0, 1, 0, 4'b1111);
    chk("basic_out0", 32'(outstanding), 32'd2);
    adv();
    cyc(1, 0, 0, 1, 2, 4'b1111);
    chk("basic_bvld0", 32'(slave_bvld), 32'h4);
    chk("basic_b0", 32'(slave_b[2*BW +: BW]), 32'd0);
    chk("basic_out1", 32'(outstanding), 32'd2);
    adv();
    cyc(1, 0, 0, 0, 0, 4'b1111);
    chk("basic_bvld1", 32'(slave_bvld), 32'h1);
    chk("basic_b1", 32'(slave_b[0 +: BW]), 32'd2);
    chk("basic_out2", 32'(outstanding), 32'd1);
    adv();
    cyc(1, 0, 0, 0, 0, 4'b1111);
    chk("basic_out3", 32'(outstanding), 32'd0);
    adv();

    // Empty stall, then push idx 3
    step(0, 0, 0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 1, 1, 4'b1111);
    chk("empty_brdy", 32'(master_brdy), 32'd0);
    chk("empty_bvld", 32'(slave_bvld), 32'd0);
    adv();
    cyc(1, 1, 3, 1, 1, 4'b1111);
    chk("empty_brdy_t", 32'(master_brdy), 32'd0);
    adv();
    cyc(1, 0, 0, 1, 1, 4'b1111);
    chk("empty_brdy_t1", 32'(master_brdy), 32'd1);
    adv();
    cyc(1, 0, 0, 0, 0, 4'b1111);
    chk("empty_bvld_t2", 32'(slave_bvld), 32'h8);
    adv();

    // Backpressure on input 1
    step(0, 0, 0, 0, 0, 4'b0000);
    step(1, 1, 1, 0, 0, 4'b0000);
    step(1, 1, 1, 0, 0, 4'b0000);
    step(1, 0, 0, 1, 1, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 1, 3, 4'b1101);
      chk("bp_hold_bvld", 32'(slave_bvld), 32'h2);
      chk("bp_hold_b", 32'(slave_b[BW +: BW]), 32'd1);
      chk("bp_hold_brdy", 32'(master_brdy), 32'd0);
      adv();
    end
    cyc(1, 0, 0, 1, 3, 4'b1111);
    chk("bp_release_brdy", 32'(master_brdy), 32'd1);
    adv();
    cyc(1, 0, 0, 0, 0, 4'b1111);
    chk("bp_second_bvld", 32'(slave_bvld), 32'h2);
    chk("bp_second_b", 32'(slave_b[BW +: BW]), 32'd3);
    adv();

    // Simultaneous push/pop at count = 1
    step(0, 0, 0, 0, 0, 4'b0000);
    step(1, 1, 0, 0, 0, 4'b1111);
    cyc(1, 1, 2, 1, 2, 4'b1111);
    chk("pp_brdy", 32'(master_brdy), 32'd1);
    adv();
    cyc(1, 0, 0, 1, 1, 4'b1111);
    chk("pp_bvld", 32'(slave_bvld), 32'h1);
    chk("pp_out", 32'(outstanding), 32'd2);
    adv();
    cyc(1, 0, 0, 0, 0, 4'b1111);
    chk("pp_route2", 32'(slave_bvld), 32'h4);
    chk("pp_b2", 32'(slave_b[2*BW +: BW]), 32'd1);
    adv();

    // Full, then reset mid-flight
    step(0, 0, 0, 0, 0, 4'b0000);
    step(1, 1, 1, 0, 0, 4'b0000);
    step(1, 1, 2, 0, 0, 4'b0000);
    step(1, 1, 3, 0, 0, 4'b0000);
    cyc(1, 0, 0, 1, 2, 4'b0000);
    chk("full_rdy", 32'(ord_push_rdy), 32'd0);
    chk("full_out", 32'(outstanding), 32'd3);
    adv();
    cyc(1, 0, 0, 0, 0, 4'b0000);
    chk("mid_bvld", 32'(slave_bvld), 32'h2);
    chk("mid_rdy", 32'(ord_push_rdy), 32'd1);
    adv();
    step(0, 0, 0, 0, 0, 4'b0000);
    cyc(1, 1, 0, 1, 3, 4'b1111);
    chk("post_rst_bvld", 32'(slave_bvld), 32'd0);
    chk("post_rst_out", 32'(outstanding), 32'd0);
    chk("post_rst_rdy", 32'(ord_push_rdy), 32'd1);
    chk("post_rst_brdy", 32'(master_brdy), 32'd0);
    adv();
    step(1, 0, 0, 1, 3, 4'b1111);
    cyc(1, 0, 0, 0, 0, 4'b1111);
    chk("post_rst_route", 32'(slave_bvld), 32'h1);
    adv();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic r, pv, bv;
      logic [N-1:0] sr;
      r  = ($urandom_range(0, 499) != 0);
      pv = (q.size() < D) && ($urandom_range(0, 2) != 0);
      bv = ($urandom_range(0, 2) != 0);
      sr = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : 4'b1111;
      step(r, pv, int'($urandom_range(0, N - 1)), bv, int'($urandom_range(0, 3)), sr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
